instr_fetch_mem: RTL and testbench

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_mem.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// instr_fetch_mem
//
// Cell-organised instruction memory with a multi-cycle fetch engine. The
// memory holds MEM_SIZE cells of CELL_SIZE bits. A fetch gathers
// N = WORD_LEN/CELL_SIZE consecutive cells, one per clock, starting at the
// requested cell address. The lowest-address cell becomes the most
// significant cell of the instruction. Cell addresses wrap modulo MEM_SIZE.
// A request whose address has any bit set above the array's address range
// still takes N cycles. It then completes with fetch_err=1 and a zero
// instruction.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset (cell contents are kept)
//   prog_en      programming mode; blocks new fetches and aborts a running one
//   prog_we      cell write strobe, honoured only while prog_en=1
//   prog_addr    cell address for a programming write (AW bits)
//   prog_data    cell write data (CELL_SIZE bits)
//   fetch_req    fetch request
//   fetch_addr   cell address of the first (most significant) cell
//   fetch_ready  request is accepted this cycle if fetch_req=1
//   fetch_valid  one-cycle pulse: instruction/fetch_err have just updated
//   instruction  assembled instruction, held until the next completion
//   fetch_err    completed fetch had an out-of-range address
// ---------------------------------------------------------------------------
module instr_fetch_mem #(
    parameter int WORD_LEN  = 16,
    parameter int CELL_SIZE = 4,
    parameter int MEM_SIZE  = 256,
    localparam int AW       = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prog_en,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [CELL_SIZE-1:0] prog_data,
    input  logic                 fetch_req,
    input  logic [WORD_LEN-1:0]  fetch_addr,
    output logic                 fetch_ready,
    output logic                 fetch_valid,
    output logic [WORD_LEN-1:0]  instruction,
    output logic                 fetch_err
);

    localparam int N  = WORD_LEN / CELL_SIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] GATHER = 1'b1;

    logic [CELL_SIZE-1:0] mem [MEM_SIZE];

    logic [0:0]           state;
    logic [AW-1:0]        base;
    logic [CW-1:0]        cnt;
    logic                 err_q;
    logic [WORD_LEN-1:0]  gather_buf;

    logic [AW-1:0]        rd_addr;
    logic [CELL_SIZE-1:0] rd_cell;
    logic [WORD_LEN-1:0]  next_buf;
    logic                 accept;
    logic                 addr_out_of_range;

    // fetch_ready is gated by rst so that it reads low during reset, not
    // just after the state register has settled.
    assign fetch_ready = (state == IDLE) && !prog_en && rst;
    assign accept      = fetch_req && fetch_ready;

    // Any address bit above the array range marks the fetch as erroneous.
    assign addr_out_of_range = (fetch_addr >> AW) != '0;

    // Combinational read of the current cell. The AW-bit sum wraps
    // naturally, so a fetch near the top of the array continues at cell 0.
    // The new cell enters the buffer from the LSB side, so the first cell
    // read ends up as the most significant cell.
    always_comb begin
        rd_addr  = base + AW'(cnt);
        rd_cell  = mem[rd_addr];
        next_buf = (gather_buf << CELL_SIZE) | WORD_LEN'(rd_cell);
    end

    // Programming writes. This block has no reset, so reset leaves the
    // program image intact. Writes and fetches never overlap because
    // prog_en blocks and aborts fetches.
    always_ff @(posedge clk) begin
        if (prog_en && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Fetch engine. IDLE accepts a request and latches its base and error
    // flag. GATHER takes one cell per edge. On the last cell it publishes
    // the result and raises fetch_valid for one cycle. Because the FSM is
    // back in IDLE during that cycle, a new request can be accepted then.
    // prog_en during GATHER drops the fetch without touching the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            base        <= '0;
            cnt         <= '0;
            err_q       <= 1'b0;
            gather_buf  <= '0;
            fetch_valid <= 1'b0;
            instruction <= '0;
            fetch_err   <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        base       <= fetch_addr[AW-1:0];
                        cnt        <= '0;
                        err_q      <= addr_out_of_range;
                        gather_buf <= '0;
                        state      <= GATHER;
                    end
                end
                GATHER: begin
                    if (prog_en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        gather_buf <= next_buf;
                        cnt        <= cnt + CW'(1);
                        if (cnt == LAST_CNT) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            fetch_valid <= 1'b1;
                            instruction <= err_q ? '0 : next_buf;
                            fetch_err   <= err_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_mem
//
// Directed bench for instr_fetch_mem with WORD_LEN=16, CELL_SIZE=4 and
// MEM_SIZE=64. Inputs change on the falling edge. Outputs are sampled on
// the falling edge, away from the rising edge that the DUT uses.
// ---------------------------------------------------------------------------
module tb_instr_fetch_mem;

    localparam int WORD_LEN  = 16;
    localparam int CELL_SIZE = 4;
    localparam int MEM_SIZE  = 64;
    localparam int AW        = 6;

    logic                 clk;
    logic                 rst;
    logic                 prog_en;
    logic                 prog_we;
    logic [AW-1:0]        prog_addr;
    logic [CELL_SIZE-1:0] prog_data;
    logic                 fetch_req;
    logic [WORD_LEN-1:0]  fetch_addr;
    logic                 fetch_ready;
    logic                 fetch_valid;
    logic [WORD_LEN-1:0]  instruction;
    logic                 fetch_err;

    int compared   = 0;
    int mismatched = 0;

    instr_fetch_mem #(
        .WORD_LEN (WORD_LEN),
        .CELL_SIZE(CELL_SIZE),
        .MEM_SIZE (MEM_SIZE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_en    (prog_en),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .instruction(instruction),
        .fetch_err  (fetch_err)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point. It counts each comparison and reports any
    // mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one programming cycle, then returns at the next falling edge.
    task automatic applyStimulus(input logic pe, input logic pw,
                                 input logic [AW-1:0] pa,
                                 input logic [CELL_SIZE-1:0] pd);
        prog_en   = pe;
        prog_we   = pw;
        prog_addr = pa;
        prog_data = pd;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts at the falling edge after an accept. Returns how many rising
    // edges it took for fetch_valid to appear (0 if it never appeared within
    // the budget). Also returns how many sampled cycles had fetch_ready low.
    task automatic waitValid(output int latency, output int ready_low);
        latency   = 0;
        ready_low = 0;
        for (int i = 1; i <= 12; i++) begin
            if (!fetch_ready) ready_low++;
            @(posedge clk);
            @(negedge clk);
            if (fetch_valid) begin
                latency = i;
                break;
            end
        end
    endtask

    // Runs one complete fetch and checks its latency, busy window and
    // result. It also checks that the valid pulse lasts one cycle and the
    // result is held afterwards.
    task automatic doFetch(input string tag, input logic [WORD_LEN-1:0] addr,
                           input logic [WORD_LEN-1:0] exp_instr, input logic exp_err);
        int lat;
        int rl;
        checkOutput({tag, "_ready"}, 32'(fetch_ready), 32'd1);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        waitValid(lat, rl);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_busy"}, 32'(rl), 32'd4);
        checkOutput({tag, "_instr"}, 32'(instruction), 32'(exp_instr));
        checkOutput({tag, "_err"}, 32'(fetch_err), 32'(exp_err));
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 32'(fetch_valid), 32'd0);
        checkOutput({tag, "_held"}, 32'(instruction), 32'(exp_instr));
    endtask

    initial begin
        int lat;
        int rl;
        int seen_valid;

        rst        = 1'b0;
        prog_en    = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(fetch_valid), 32'd0);
        checkOutput("rst_instr", 32'(instruction), 32'd0);
        checkOutput("rst_err", 32'(fetch_err), 32'd0);
        checkOutput("rst_ready", 32'(fetch_ready), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rel_ready", 32'(fetch_ready), 32'd1);
        @(negedge clk);

        // Program image: 8..11 = 3,1,0,A; 12..15 = 5,E,7,2; 62,63,0,1 = C,3,1,1.
        applyStimulus(1'b1, 1'b1, 6'd8,  4'h3);
        applyStimulus(1'b1, 1'b1, 6'd9,  4'h1);
        applyStimulus(1'b1, 1'b1, 6'd10, 4'h0);
        applyStimulus(1'b1, 1'b1, 6'd11, 4'hA);
        applyStimulus(1'b1, 1'b1, 6'd12, 4'h5);
        applyStimulus(1'b1, 1'b1, 6'd13, 4'hE);
        applyStimulus(1'b1, 1'b1, 6'd14, 4'h7);
        applyStimulus(1'b1, 1'b1, 6'd15, 4'h2);
        applyStimulus(1'b1, 1'b1, 6'd62, 4'hC);
        applyStimulus(1'b1, 1'b1, 6'd63, 4'h3);
        applyStimulus(1'b1, 1'b1, 6'd0,  4'h1);
        applyStimulus(1'b1, 1'b1, 6'd1,  4'h1);
        checkOutput("prog_ready", 32'(fetch_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0);

        // Basic fetch, a fetch that wraps, an out-of-range fetch, then a
        // good fetch that clears the error.
        doFetch("f8", 16'd8, 16'h310A, 1'b0);
        doFetch("wrap", 16'd62, 16'hC311, 1'b0);
        doFetch("oor", 16'h0040, 16'h0000, 1'b1);
        doFetch("clr", 16'd8, 16'h310A, 1'b0);

        // Abort: raise prog_en during the second gather cycle.
        seen_valid = 0;
        fetch_req  = 1'b1;
        fetch_addr = 16'd62;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        prog_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fetch_valid) seen_valid++;
            checkOutput("abort_ready", 32'(fetch_ready), 32'd0);
        end
        prog_en = 1'b0;
        #1;
        checkOutput("abort_ready_back", 32'(fetch_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fetch_valid) seen_valid++;
        end
        checkOutput("abort_novalid", 32'(seen_valid), 32'd0);
        checkOutput("abort_instr", 32'(instruction), 32'h310A);
        checkOutput("abort_err", 32'(fetch_err), 32'd0);

        // Back-to-back: hold fetch_req. The second request (addr 12) is
        // taken during the first fetch's valid cycle.
        fetch_req  = 1'b1;
        fetch_addr = 16'd8;
        @(posedge clk);
        @(negedge clk);
        fetch_addr = 16'd12;
        waitValid(lat, rl);
        checkOutput("b2b1_latency", 32'(lat), 32'd4);
        checkOutput("b2b1_instr", 32'(instruction), 32'h310A);
        checkOutput("b2b1_ready", 32'(fetch_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        waitValid(lat, rl);
        checkOutput("b2b2_latency", 32'(lat), 32'd4);
        checkOutput("b2b2_instr", 32'(instruction), 32'h5E72);
        checkOutput("b2b2_err", 32'(fetch_err), 32'd0);
        @(posedge clk);
        @(negedge clk);

        // Reset mid-fetch, asserted between clock edges.
        seen_valid = 0;
        fetch_req  = 1'b1;
        fetch_addr = 16'd62;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_instr", 32'(instruction), 32'd0);
        checkOutput("arst_valid", 32'(fetch_valid), 32'd0);
        checkOutput("arst_err", 32'(fetch_err), 32'd0);
        checkOutput("arst_ready", 32'(fetch_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fetch_valid) seen_valid++;
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fetch_valid) seen_valid++;
        end
        checkOutput("arst_novalid", 32'(seen_valid), 32'd0);
        doFetch("post_rst", 16'd8, 16'h310A, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Backstop so the run always ends, even if a wait somewhere never returns.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
